// File: rtl/sap_control_sequencer_if.sv
// Signal bundle between the SAP-1 control sequencer and the datapath/IR side.
interface sap_control_sequencer_if;
  logic        run;
  logic [3:0]  instruction;
  logic [11:0] control_word;
  logic [5:0]  t_state;
  logic        halted;

  // Sequencer side: consumes run/opcode, produces the control word and status.
  modport slave (
    input  run,
    input  instruction,
    output control_word,
    output t_state,
    output halted
  );

  // Datapath/controller side: supplies run/opcode, observes the sequencer.
  modport master (
    output run,
    output instruction,
    input  control_word,
    input  t_state,
    input  halted
  );
endinterface

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: one-hot T1..T6 ring counter, opcode decode and
// sticky halt. Drives the 12-bit control word
// {Cp,Ep,Lm_n,Ce_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}.
module sap_control_sequencer (
  input  logic                         clock,
  input  logic                         reset,
  sap_control_sequencer_if.slave       bus
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [11:0] CW_NOP     = 12'h3E3;
  localparam logic [11:0] CW_FETCH1  = 12'h5E3;
  localparam logic [11:0] CW_FETCH2  = 12'hBE3;
  localparam logic [11:0] CW_FETCH3  = 12'h263;
  localparam logic [11:0] CW_ADDR    = 12'h1A3;
  localparam logic [11:0] CW_LDA_T5  = 12'h2C3;
  localparam logic [11:0] CW_LDB     = 12'h2E1;
  localparam logic [11:0] CW_ADD_T6  = 12'h3C7;
  localparam logic [11:0] CW_SUB_T6  = 12'h3CF;
  localparam logic [11:0] CW_OUT_T4  = 12'h3F2;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_e;

  ring_e       ring;
  logic        halted_q;
  logic [11:0] word;

  // Ring counter and halt flag; a corrupted (non-one-hot) ring snaps back to T1.
  always_ff @(posedge clock) begin
    if (reset) begin
      ring     <= T1;
      halted_q <= 1'b0;
    end else if (!$onehot(ring)) begin
      ring <= T1;
    end else if (bus.run && !halted_q) begin
      case (ring)
        T1: ring <= T2;
        T2: ring <= T3;
        T3: ring <= T4;
        T4: begin
          ring <= T5;
          if (bus.instruction == OP_HLT) halted_q <= 1'b1;
        end
        T5: ring <= T6;
        T6: ring <= T1;
        default: ring <= T1;
      endcase
    end
  end

  // Moore decode of the current T-state and opcode; reset and halt force NOP.
  always_comb begin
    word = CW_NOP;
    if (!reset && !halted_q) begin
      case (ring)
        T1: word = CW_FETCH1;
        T2: word = CW_FETCH2;
        T3: word = CW_FETCH3;
        T4: begin
          case (bus.instruction)
            OP_LDA, OP_ADD, OP_SUB: word = CW_ADDR;
            OP_OUT:                 word = CW_OUT_T4;
            default:                word = CW_NOP;
          endcase
        end
        T5: begin
          case (bus.instruction)
            OP_LDA:         word = CW_LDA_T5;
            OP_ADD, OP_SUB: word = CW_LDB;
            default:        word = CW_NOP;
          endcase
        end
        T6: begin
          case (bus.instruction)
            OP_ADD:  word = CW_ADD_T6;
            OP_SUB:  word = CW_SUB_T6;
            default: word = CW_NOP;
          endcase
        end
        default: word = CW_NOP;
      endcase
    end
  end

  assign bus.control_word = word;
  assign bus.t_state      = ring;
  assign bus.halted       = halted_q;

  // At most one bus driver (Ep, Ce, Ei, Ea, Eu) may be enabled in any T-state.
  a_single_driver: assert property (@(posedge clock)
    $onehot0({word[10], ~word[8], ~word[6], word[4], word[2]}));

endmodule
